// File: rtl/swim_cmd_ctrl.sv
// Byte-command sequencer for the SWIM entry generator: decodes host commands,
// launches and supervises the entry sequence, and answers each command with one byte.
module swim_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 40000000,
    parameter int TO_W           = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       seq_start,
    input  logic       seq_done,
    output logic       tgt_rst_hold,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, RSP} state_t;

    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HOLD = 8'h48;
    localparam logic [7:0] CMD_REL  = 8'h4C;
    localparam logic [7:0] CMD_STAT = 8'h53;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BLK  = 8'h42;
    localparam logic [7:0] RSP_TO   = 8'h54;
    localparam logic [7:0] RSP_UNK  = 8'h3F;

    state_t          state;
    logic [TO_W-1:0] watchdog;
    logic [3:0]      run_count;
    logic            last_timeout;

    assign cmd_ready = (state == IDLE) && !rsp_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            watchdog     <= '0;
            run_count    <= '0;
            last_timeout <= 1'b0;
            rsp_data     <= '0;
            rsp_valid    <= 1'b0;
            seq_start    <= 1'b0;
            tgt_rst_hold <= 1'b0;
            busy         <= 1'b0;
        end else begin
            seq_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // Every branch except a real launch answers immediately
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        case (cmd_data)
                            CMD_RUN: begin
                                if (tgt_rst_hold) begin
                                    rsp_data <= RSP_BLK;
                                end else begin
                                    state     <= RUN;
                                    rsp_valid <= 1'b0;
                                    seq_start <= 1'b1;
                                    busy      <= 1'b1;
                                    watchdog  <= TO_LOAD;
                                end
                            end
                            CMD_HOLD: begin
                                tgt_rst_hold <= 1'b1;
                                rsp_data     <= RSP_OK;
                            end
                            CMD_REL: begin
                                tgt_rst_hold <= 1'b0;
                                rsp_data     <= RSP_OK;
                            end
                            CMD_STAT: rsp_data <= {2'b01, last_timeout, 1'b0, run_count};
                            default:  rsp_data <= RSP_UNK;
                        endcase
                    end
                end
                RUN: begin
                    // Completion is checked first so a coincident done beats the timeout
                    if (seq_done) begin
                        if (run_count != 4'hF) run_count <= run_count + 4'd1;
                        last_timeout <= 1'b0;
                        rsp_data     <= RSP_OK;
                        rsp_valid    <= 1'b1;
                        busy         <= 1'b0;
                        watchdog     <= '0;
                        state        <= RSP;
                    end else if (watchdog == '0) begin
                        last_timeout <= 1'b1;
                        rsp_data     <= RSP_TO;
                        rsp_valid    <= 1'b1;
                        busy         <= 1'b0;
                        state        <= RSP;
                    end else begin
                        watchdog <= watchdog - TO_ONE;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
